bit_clk_recovery_p: RTL and testbench
=====================================

BIT_CLK_RECOVERY_P -- requirements
Module: bit_clk_recovery_p

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of all interval and phase counters.
REQ-002 SHALL provide parameter INIT_PERIOD, default 801: reset value of clk_freq, in clk_200M cycles.
REQ-003 SHALL provide parameter RELAX_EDGES, default 16: count of non-shrinking edges before clk_freq relaxes by +1.
REQ-004 SHALL provide parameter LOCK_EDGES, default 8: count of consecutive non-shrinking edges required to assert locked.
REQ-005 SHALL provide parameter MIN_INTERVAL, default 4: shortest accepted interval when the glitch filter is compiled in.
REQ-006 SHALL provide port clk_200M  input  1: sole clock, all logic on its rising edge.
REQ-007 SHALL provide port rst_n  input  1: asynchronous active-low reset.
REQ-008 SHALL provide port signal  input  1: asynchronous serial data.
REQ-009 SHALL provide port clk_rec  output  1: recovered bit clock.
REQ-010 SHALL provide port clk_freq  output  CNT_W: current bit-period estimate, in clk_200M cycles.
REQ-011 SHALL provide port bit_valid  output  1: one-cycle strobe marking a sampled bit.
REQ-012 SHALL provide port bit_data  output  1: sampled bit, valid while bit_valid=1.
REQ-013 SHALL provide port locked  output  1: period estimate stable.

Function
REQ-014 SHALL pass signal through a 2-flop synchronizer; all edge logic SHALL use the second stage (sig_s) and its one-cycle delayed copy.
REQ-015 SHALL declare an edge on any cycle where sig_s differs from its delayed copy; edge-to-edge latency from a signal change is 3 cycles.
REQ-016 SHALL increment the interval counter on every non-edge cycle, saturating at all-ones, and SHALL clear it to 0 on an edge.
REQ-017 On an edge with interval < clk_freq and interval != all-ones (and interval >= MIN_INTERVAL when filtered), SHALL load clk_freq <= interval and clear the relax and lock counters ("shrink edge").
REQ-018 On any other edge, SHALL increment the relax counter; when it equals RELAX_EDGES-1, SHALL set clk_freq <= clk_freq+1 (saturating at all-ones) and clear the relax counter.
REQ-019 SHALL let a shrink take priority over a relax when both conditions fall on the same edge.
REQ-020 SHALL derive half = clk_freq>>1 and quarter = clk_freq>>2, using the clk_freq value registered before the current cycle.
REQ-021 SHALL increment a phase counter every cycle; when phase+1 >= half, SHALL clear phase and toggle clk_rec.
REQ-022 On an edge with phase >= quarter and no half-period toggle pending, SHALL clear phase and toggle clk_rec (phase realignment).
REQ-023 SHALL treat half = 0 as 1, so clk_rec toggles every cycle rather than stalling.
REQ-024 On each 0->1 transition of clk_rec, SHALL pulse bit_valid for exactly one cycle with bit_data = sig_s of that cycle.
REQ-025 SHALL increment the lock counter on each non-shrink edge, saturating at LOCK_EDGES, and SHALL hold locked=1 while it equals LOCK_EDGES.
REQ-026 SHALL clear the lock counter and deassert locked on a shrink edge or when the interval counter saturates (idle line); clk_freq SHALL hold its value on saturation.

Reset
REQ-027 On rst_n=0, SHALL immediately set clk_rec=0, clk_freq=INIT_PERIOD, bit_valid=0, bit_data=0, locked=0, and clear all counters and synchronizer flops.
REQ-028 SHALL ignore a signal edge coincident with reset release; interval measurement SHALL begin on the first post-reset edge.

Configuration
REQ-029 With macro BCR_GLITCH_FILTER_EN defined, SHALL ignore edges whose interval < MIN_INTERVAL for shrink, relax and lock purposes, while still clearing the interval counter.
REQ-030 Without BCR_GLITCH_FILTER_EN, SHALL treat every edge per REQ-017/018, and MIN_INTERVAL SHALL be unused.

Verification
REQ-031 SHALL verify: reset, then alternating signal with a 200-cycle period -> clk_freq=200 after the second edge, clk_rec period 200 cycles +/-2.
REQ-032 SHALL verify: locked at 200, then LOCK_EDGES+RELAX_EDGES edges at interval 250 -> clk_freq=201 and locked=1.
REQ-033 SHALL verify: signal held constant for 2^CNT_W cycles -> locked=0 and clk_freq unchanged.
REQ-034 SHALL verify, filter compiled in: a 2-cycle glitch inside a 200-cycle bit -> clk_freq stays 200; filter compiled out: clk_freq=2.
REQ-035 SHALL verify: PRBS7 at 200 cycles/bit -> bit_data sequence matches the transmitted sequence after lock, with one bit_valid per bit.
REQ-036 SHALL verify: rst_n pulsed low mid-stream -> all outputs at reset values within the same cycle, and re-acquisition per REQ-031.

Source files
------------

// File: rtl/bit_clk_recovery_p.sv
`default_nettype none
// ============================================================================
// Module   : bit_clk_recovery_p
// Brief    : Recovers a bit clock, sampled data and a lock flag from an async
//            serial line by tracking the shortest edge-to-edge interval.
//            Optional glitch filter: define BCR_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module bit_clk_recovery_p #(
    parameter int CNT_W        = 16,
    parameter int INIT_PERIOD  = 801,
    parameter int RELAX_EDGES  = 16,
    parameter int LOCK_EDGES   = 8,
    parameter int MIN_INTERVAL = 4
) (
    input  logic             clk_200M,
    input  logic             rst_n,
    input  logic             signal,
    output logic             clk_rec,
    output logic [CNT_W-1:0] clk_freq,
    output logic             bit_valid,
    output logic             bit_data,
    output logic             locked
);

    localparam int                LOCK_W     = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FREQ_RST   = CNT_W'(INIT_PERIOD);
    localparam logic [CNT_W-1:0]  RELAX_LAST = CNT_W'(RELAX_EDGES - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL  = LOCK_W'(LOCK_EDGES);
    localparam logic [LOCK_W-1:0] LOCK_ONE   = LOCK_W'(1);

    logic             sync1_q, sync1_d;
    logic             sig_s_q, sig_s_d;
    logic             sig_d_q, sig_d_d;
    logic [1:0]       prime_q, prime_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic [CNT_W-1:0] relax_q, relax_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             clk_rec_q, clk_rec_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_data_q, bit_data_d;

    logic             edge_det;
    logic             long_enough;
    logic             meas_edge;
    logic             shrink_edge;
    logic             other_edge;
    logic [CNT_W-1:0] interval_cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_eff;
    logic [CNT_W-1:0] quarter;
    logic [CNT_W-1:0] phase_inc;
    logic             toggle;

    // Edges are only trusted once sig_d holds a post-reset sample, so a level
    // present at reset release is not mistaken for a transition.
    always_comb begin
        sync1_d = signal;
        sig_s_d = sync1_q;
        sig_d_d = sig_s_q;
        prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    end

    assign edge_det     = (prime_q == 2'd3) && (sig_s_q != sig_d_q);
    assign interval_cnt = (interval_q == CNT_MAX) ? CNT_MAX : interval_q + ONE;

`ifdef BCR_GLITCH_FILTER_EN
    assign long_enough = (interval_cnt >= CNT_W'(MIN_INTERVAL));
`else
    assign long_enough = 1'b1;
`endif

    // The first edge after reset only starts the interval measurement.
    assign meas_edge   = edge_det && started_q && long_enough;
    assign shrink_edge = meas_edge && (interval_cnt < freq_q) && (interval_cnt != CNT_MAX);
    assign other_edge  = meas_edge && !shrink_edge;

    always_comb begin
        interval_d = edge_det ? '0 : interval_cnt;
        started_d  = started_q | edge_det;
        freq_d     = freq_q;
        relax_d    = relax_q;
        lock_d     = lock_q;

        if (shrink_edge) begin
            freq_d  = interval_cnt;
            relax_d = '0;
        end else if (other_edge) begin
            if (relax_q == RELAX_LAST) begin
                relax_d = '0;
                if (freq_q != CNT_MAX) begin
                    freq_d = freq_q + ONE;
                end
            end else begin
                relax_d = relax_q + ONE;
            end
        end

        if (shrink_edge || (interval_q == CNT_MAX)) begin
            lock_d = '0;
        end else if (other_edge && (lock_q != LOCK_FULL)) begin
            lock_d = lock_q + LOCK_ONE;
        end
    end

    always_comb begin
        half      = {1'b0, freq_q[CNT_W-1:1]};
        half_eff  = (half == '0) ? ONE : half;
        quarter   = {2'b00, freq_q[CNT_W-1:2]};
        phase_inc = phase_q + ONE;
        phase_d   = phase_inc;
        toggle    = 1'b0;

        if (phase_inc >= half_eff) begin
            phase_d = '0;
            toggle  = 1'b1;
        end else if (edge_det && long_enough && (phase_q >= quarter)) begin
            // Late edge: pull the recovered clock back onto the data transition.
            phase_d = '0;
            toggle  = 1'b1;
        end

        clk_rec_d   = clk_rec_q ^ toggle;
        bit_valid_d = toggle && !clk_rec_q;
        bit_data_d  = (toggle && !clk_rec_q) ? sig_s_q : bit_data_q;
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sig_s_q     <= 1'b0;
            sig_d_q     <= 1'b0;
            prime_q     <= 2'd0;
            started_q   <= 1'b0;
            interval_q  <= '0;
            freq_q      <= FREQ_RST;
            relax_q     <= '0;
            lock_q      <= '0;
            phase_q     <= '0;
            clk_rec_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sig_s_q     <= sig_s_d;
            sig_d_q     <= sig_d_d;
            prime_q     <= prime_d;
            started_q   <= started_d;
            interval_q  <= interval_d;
            freq_q      <= freq_d;
            relax_q     <= relax_d;
            lock_q      <= lock_d;
            phase_q     <= phase_d;
            clk_rec_q   <= clk_rec_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
        end
    end

    assign clk_rec   = clk_rec_q;
    assign clk_freq  = freq_q;
    assign bit_valid = bit_valid_q;
    assign bit_data  = bit_data_q;
    assign locked    = (lock_q == LOCK_FULL);

endmodule
`default_nettype wire

// File: tb/tb_bit_clk_recovery_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_clk_recovery_p
// Brief    : Self-checking bench for bit_clk_recovery_p (CNT_W reduced to 12).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bit_clk_recovery_p;

    localparam int CNT_W = 12;

    logic             clk;
    logic             rst_n;
    logic             signal;
    logic             clk_rec;
    logic [CNT_W-1:0] clk_freq;
    logic             bit_valid;
    logic             bit_data;
    logic             locked;

    bit_clk_recovery_p #(.CNT_W(CNT_W)) dut (
        .clk_200M (clk),
        .rst_n    (rst_n),
        .signal   (signal),
        .clk_rec  (clk_rec),
        .clk_freq (clk_freq),
        .bit_valid(bit_valid),
        .bit_data (bit_data),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rec_last = 0;
    int   rec_period = 0;
    logic rec_prev = 1'b0;
    bit   mon_en = 1'b0;
    int   n_valid = 0;
    logic exp_q[$];
    logic exp_bit;
    logic [6:0] lfsr;
    int   glitch_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges; track clk_rec rises and drain the bit scoreboard.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (clk_rec && !rec_prev) begin
                rec_period = cyc - rec_last;
                rec_last   = cyc;
            end
            rec_prev = clk_rec;
            if (mon_en && bit_valid) begin
                n_valid++;
                check_eq("prbs_queue_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_bit = exp_q.pop_front();
                    check_eq("prbs_bit", bit_data, exp_bit);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_clk_rec"},   clk_rec,   0);
        check_eq({tag, "_clk_freq"},  clk_freq,  801);
        check_eq({tag, "_bit_valid"}, bit_valid, 0);
        check_eq({tag, "_bit_data"},  bit_data,  0);
        check_eq({tag, "_locked"},    locked,    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        signal = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(10);

        // Acquisition at 200, lock, relax to 201 and shrink back to 200.
        for (int k = 1; k <= 19; k++) begin
            signal = ~signal;
            tick(4);
            if (k == 1)  check_eq("first_edge_freq", clk_freq, 801);
            if (k == 2)  check_eq("acq_freq_200", clk_freq, 200);
            if (k == 9)  check_eq("not_locked_e9", locked, 0);
            if (k == 10) check_eq("locked_e10", locked, 1);
            if (k == 16) check_eq("rec_period_200", (rec_period >= 198 && rec_period <= 202), 1);
            if (k == 18) check_eq("relax_freq_201", clk_freq, 201);
            if (k == 19) begin
                check_eq("shrink_freq_200", clk_freq, 200);
                check_eq("shrink_unlock", locked, 0);
            end
            tick(196);
        end
        tick(50);

        // LOCK_EDGES + RELAX_EDGES edges at interval 250.
        for (int k = 1; k <= 24; k++) begin
            signal = ~signal;
            tick(4);
            if (k == 8)  check_eq("lock_250", locked, 1);
            if (k == 15) check_eq("pre_relax_250", clk_freq, 200);
            if (k == 24) begin
                check_eq("relax_250_freq", clk_freq, 201);
                check_eq("relax_250_locked", locked, 1);
            end
            tick(246);
        end

        // Idle line until the interval counter saturates.
        tick(4200);
        check_eq("idle_unlock", locked, 0);
        check_eq("idle_freq_hold", clk_freq, 201);

        // Reset pulsed mid-stream.
        for (int k = 0; k < 5; k++) begin
            signal = ~signal;
            tick(200);
        end
        tick(37);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        signal = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        signal = 1'b0;
        tick(4);
        check_eq("reacq_first_edge", clk_freq, 801);
        tick(196);
        signal = 1'b1;
        tick(4);
        check_eq("reacq_freq_200", clk_freq, 200);
        tick(196);
        for (int k = 0; k < 2; k++) begin
            signal = ~signal;
            tick(200);
        end

        // Two-cycle glitch inside a held bit.
`ifdef BCR_GLITCH_FILTER_EN
        glitch_exp = 200;
`else
        glitch_exp = 2;
`endif
        tick(100);
        signal = ~signal;
        tick(2);
        signal = ~signal;
        tick(4);
        check_eq("glitch_freq", clk_freq, glitch_exp);
        tick(300);

        // PRBS7 after an alternating preamble.
        rst_n  = 1'b0;
        signal = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        for (int k = 1; k <= 30; k++) begin
            signal = (k % 2 == 1);
            tick(200);
        end
        check_eq("preamble_locked", locked, 1);
        lfsr = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            signal = lfsr[6];
            exp_q.push_back(lfsr[6]);
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            if (i == 0) begin
                tick(2);
                mon_en = 1'b1;
                tick(198);
            end else begin
                tick(200);
            end
        end
        tick(2);
        mon_en = 1'b0;
        check_eq("prbs_valid_count", n_valid, 127);
        check_eq("prbs_leftover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
